mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single slow main-memory port between the I-cache and D-cache miss/write-back engines of the pipelined CPU.
- Sits between the two caches and the memory model, as a 2:1 arbiter.
- Grants one whole transaction at a time and latches the winner's command onto the memory bus.
- Routes mem_ready back only to the current owner.
- Default policy: D-cache has priority, with a starvation guard for the I-cache.

Parameters:
- ADDR_W, 28, block address width (word address [31:4]).
- DATA_W, 128, cache-line width.
- STARVE_LIMIT, 4, maximum consecutive D grants while an I request waits; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ic_mem_read  in  1  I-cache line-fill request, held until ic_mem_ready.
- ic_mem_addr  in  ADDR_W  I-cache line address.
- ic_mem_rdata  out  DATA_W  read data to I-cache (= mem_rdata).
- ic_mem_ready  out  1  transaction done for I-cache.
- dc_mem_read  in  1  D-cache fill request.
- dc_mem_write  in  1  D-cache write-back request.
- dc_mem_addr  in  ADDR_W  D-cache line address.
- dc_mem_wdata  in  DATA_W  D-cache write-back line.
- dc_mem_rdata  out  DATA_W  read data to D-cache (= mem_rdata).
- dc_mem_ready  out  1  transaction done for D-cache.
- mem_read  out  1  memory read command (registered).
- mem_write  out  1  memory write command (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  one-cycle completion pulse from memory.
- owner  out  1  0 = I-cache, 1 = D-cache; valid while busy.
- busy  out  1  high in GRANT_I and GRANT_D.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - mem_read, mem_write, mem_addr, mem_wdata, owner, busy all 0.
  - d_streak=0.
- ic_mem_ready and dc_mem_ready are combinational, so they are 0 during reset.
- FSM states: IDLE, GRANT_I, GRANT_D, GAP.
- IDLE:
  - Request flags: ireq = ic_mem_read; dreq = dc_mem_read | dc_mem_write.
  - Neither requesting: stay in IDLE.
  - Only ireq: go to GRANT_I.
  - Only dreq: go to GRANT_D.
  - Both: go to GRANT_D unless d_streak == STARVE_LIMIT, in which case go to GRANT_I.
  - At the grant edge, register the winner's command:
    - mem_addr <= winner address.
    - mem_read <= read request.
    - mem_write <= dc_mem_write (D only).
    - mem_wdata <= dc_mem_wdata (D only, else unchanged).
  - If dc_mem_read and dc_mem_write are both set, write wins: mem_write=1, mem_read=0.
- Latency: request sampled at edge N; mem_read/mem_write visible after edge N; earliest completion is the cycle memory pulses mem_ready.
- GRANT_x:
  - Registered memory outputs are held constant; input changes are ignored.
  - Owner's ready output = mem_ready (same cycle, combinational). The other requester's ready stays 0.
  - Both rdata outputs always pass mem_rdata through; only ready qualifies them.
  - On mem_ready=1: clear mem_read/mem_write at the next edge and go to GAP.
- GAP: one-cycle bubble, no grant. It lets the owner drop its registered request and guarantees memory sees a deassert between transactions. Then go to IDLE.
- d_streak update, applied on each grant edge:
  - D granted while ireq=1: d_streak <= d_streak+1, saturating at STARVE_LIMIT.
  - I granted: d_streak <= 0.
  - In IDLE with ireq=0: d_streak <= 0.
- mem_ready while in IDLE or GAP is ignored; both ready outputs stay 0.
- Reset mid-transaction: the transaction is abandoned and outputs clear immediately. Requesters re-issue their requests after reset.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - Simultaneous requests are granted round-robin: a 1-bit last_owner register, reset 0 (I); the grant goes to the requester that was not last_owner.
  - last_owner is updated on every grant.
  - The d_streak logic and STARVE_LIMIT are unused (synthesised away).
- Undefined: fixed D priority with the starvation guard as above.

Test Plan:
- Lone I read, addr 0x0000010, memory ready after 5 cycles:
  - mem_read=1 and mem_addr=0x0000010 one cycle after the request.
  - ic_mem_ready pulses with the data; dc_mem_ready=0.
  - One GAP cycle, then IDLE.
- D write-back of 0xDEADF620… line at addr 0x00001F0, with dc_mem_read also high:
  - mem_write=1, mem_read=0, mem_wdata matches the line.
  - dc_mem_ready pulses once.
- I and D both requesting in the same IDLE cycle (default build): D granted first; I granted on the following IDLE.
- D held requesting continuously while I is pending, STARVE_LIMIT=4:
  - Exactly 4 D grants, then I is granted.
  - d_streak reads 0 after the I grant.
- Reset asserted mid-GRANT_D: mem_read, mem_write and busy drop asynchronously; after release the FSM is in IDLE and a new I request is served normally.
- ARB_RR_EN build, both caches requesting continuously: grants alternate I, D, I, D, starting with D after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - 2:1 I-cache/D-cache arbiter for the shared main-memory port
// Build option ARB_RR_EN: round-robin on simultaneous requests instead of D priority with starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_mem_read,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    output logic [DATA_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [DATA_W-1:0] dc_mem_wdata,
    output logic [DATA_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              owner,
    output logic              busy
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              owner_q, owner_d;
    logic              ireq, dreq, grant_i, grant_d;
`ifdef ARB_RR_EN
    logic              last_owner_q, last_owner_d;
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0]        d_streak_q, d_streak_d;
`endif

    assign ireq = ic_mem_read;
    assign dreq = dc_mem_read | dc_mem_write;

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
`ifdef ARB_RR_EN
        last_owner_d = last_owner_q;
`else
        d_streak_d   = d_streak_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ireq && dreq) begin
`ifdef ARB_RR_EN
                    grant_d = ~last_owner_q;
`else
                    grant_d = (d_streak_q != LIMIT);
`endif
                    grant_i = ~grant_d;
                end else begin
                    grant_i = ireq;
                    grant_d = dreq;
                end
                if (grant_i) begin
                    state_d     = S_GRANT_I;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = ic_mem_addr;
                    owner_d     = 1'b0;
                end
                if (grant_d) begin
                    // A combined read+write request is served as the write-back.
                    state_d     = S_GRANT_D;
                    mem_read_d  = dc_mem_read & ~dc_mem_write;
                    mem_write_d = dc_mem_write;
                    mem_addr_d  = dc_mem_addr;
                    mem_wdata_d = dc_mem_wdata;
                    owner_d     = 1'b1;
                end
`ifdef ARB_RR_EN
                if (grant_i || grant_d) last_owner_d = grant_d;
`else
                if (grant_d && ireq)
                    d_streak_d = (d_streak_q == LIMIT) ? d_streak_q : d_streak_q + 4'd1;
                else
                    d_streak_d = 4'd0;
`endif
            end
            S_GRANT_I, S_GRANT_D: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= 1'b0;
`ifdef ARB_RR_EN
            last_owner_q <= 1'b0;
`else
            d_streak_q   <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
`ifdef ARB_RR_EN
            last_owner_q <= last_owner_d;
`else
            d_streak_q   <= d_streak_d;
`endif
        end
    end

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign owner        = owner_q;
    assign busy         = (state_q == S_GRANT_I) || (state_q == S_GRANT_D);
    assign ic_mem_ready = (state_q == S_GRANT_I) & mem_ready;
    assign dc_mem_ready = (state_q == S_GRANT_D) & mem_ready;
    assign ic_mem_rdata = mem_rdata;
    assign dc_mem_rdata = mem_rdata;
endmodule
